// File: rtl/truth_table_scanner_if.sv
// Scanner bus: control, expected table, DUT drive/sense and scan results.
// master = stimulus/controller side, slave = the scanner.
interface truth_table_scanner_if #(
  parameter int N_IN = 5
);
  localparam int W = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [W-1:0]    exp_table;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [W-1:0]    table_out;
  logic [N_IN:0]   mismatch_cnt;
  logic            any_miss;
  logic [N_IN-1:0] first_miss_idx;
  logic            pass;

  modport master (
    output start, abort, exp_table, dut_out,
    input  dut_in, busy, done, table_out, mismatch_cnt, any_miss, first_miss_idx, pass
  );

  modport slave (
    input  start, abort, exp_table, dut_out,
    output dut_in, busy, done, table_out, mismatch_cnt, any_miss, first_miss_idx, pass
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input code of an N_IN-input Boolean block, builds its truth table and checks it.
// Each code costs SETTLE_CYCLES+1 cycles; start ignored while busy, abort ends a scan next edge.
module truth_table_scanner #(
  parameter int N_IN          = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_scanner_if.slave  sc
);
  localparam int W  = 1 << N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [N_IN-1:0] LAST_CODE   = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // With no settle time each code goes straight to its sample cycle.
  localparam state_t CODE_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [W-1:0]    exp_q;
  logic [N_IN-1:0] code;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    table_q;
  logic [N_IN:0]   mcnt;
  logic            any_q;
  logic [N_IN-1:0] first_q;
  logic            pass_q;

  logic            miss;
  logic [N_IN:0]   cnt_inc;

  assign miss    = sc.dut_out != exp_q[code];
  assign cnt_inc = mcnt + {{N_IN{1'b0}}, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      exp_q      <= '0;
      code       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      mcnt       <= '0;
      any_q      <= 1'b0;
      first_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (sc.start) begin
            exp_q      <= sc.exp_table;
            table_q    <= '0;
            mcnt       <= '0;
            any_q      <= 1'b0;
            first_q    <= '0;
            pass_q     <= 1'b0;
            code       <= '0;
            busy_q     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= CODE_ENTRY;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (sc.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            pass_q <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          // Abort takes priority over this code's capture, including the final one.
          if (sc.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            pass_q <= 1'b0;
          end else begin
            table_q[code] <= sc.dut_out;
            if (miss) begin
              mcnt <= cnt_inc;
              if (!any_q) begin
                any_q   <= 1'b1;
                first_q <= code;
              end
            end
            if (code != LAST_CODE) begin
              code       <= code + 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= CODE_ENTRY;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              pass_q <= (cnt_inc == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sc.dut_in         = code;
  assign sc.busy           = busy_q;
  assign sc.done           = done_q;
  assign sc.table_out      = table_q;
  assign sc.mismatch_cnt   = mcnt;
  assign sc.any_miss       = any_q;
  assign sc.first_miss_idx = first_q;
  assign sc.pass           = pass_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: table of full scans scored through a queue,
// plus hand sequences for start-while-busy, abort and mid-scan reset.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_r;
  logic        abort_r;
  logic        sel;
  int          mode_r;
  logic [31:0] exp_r;

  truth_table_scanner_if #(.N_IN(5)) ifa ();
  truth_table_scanner_if #(.N_IN(5)) ifb ();

  truth_table_scanner #(.N_IN(5), .SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .sc(ifa.slave));
  truth_table_scanner #(.N_IN(5), .SETTLE_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .sc(ifb.slave));

  // Boolean blocks under test: 0 parity, 1 constant one, 2 AND, other constant zero.
  function automatic logic model(input int m, input logic [4:0] x);
    case (m)
      0:       return ^x;
      1:       return 1'b1;
      2:       return &x;
      default: return 1'b0;
    endcase
  endfunction

  assign ifa.start     = start_r & ~sel;
  assign ifa.abort     = abort_r & ~sel;
  assign ifa.exp_table = exp_r;
  assign ifa.dut_out   = model(mode_r, ifa.dut_in);
  assign ifb.start     = start_r & sel;
  assign ifb.abort     = abort_r & sel;
  assign ifb.exp_table = exp_r;
  assign ifb.dut_out   = model(mode_r, ifb.dut_in);

  logic        busy_m, done_m, any_m, pass_m;
  logic [31:0] tbl_m;
  logic [5:0]  cnt_m;
  logic [4:0]  first_m, din_m;
  assign busy_m  = sel ? ifb.busy           : ifa.busy;
  assign done_m  = sel ? ifb.done           : ifa.done;
  assign any_m   = sel ? ifb.any_miss       : ifa.any_miss;
  assign pass_m  = sel ? ifb.pass           : ifa.pass;
  assign tbl_m   = sel ? ifb.table_out      : ifa.table_out;
  assign cnt_m   = sel ? ifb.mismatch_cnt   : ifa.mismatch_cnt;
  assign first_m = sel ? ifb.first_miss_idx : ifa.first_miss_idx;
  assign din_m   = sel ? ifb.dut_in         : ifa.dut_in;

  typedef struct {
    logic [31:0] tbl;
    logic [5:0]  cnt;
    logic        any;
    logic [4:0]  first;
    logic        pass;
    int          lat;
    int          hold;
  } res_t;

  typedef struct {
    logic        s;
    int          mode;
    logic [31:0] exp;
    res_t        r;
  } vec_t;

  vec_t vecs[6];
  res_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic kick(input logic s, input int m, input logic [31:0] e);
    @(negedge clk);
    sel = s; mode_r = m; exp_r = e; start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
  endtask

  task automatic wait_code(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy_m && din_m == 5'(c)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_scan(input logic s, input int m, input logic [31:0] e, input res_t r);
    int   lat;
    int   hold;
    bit   seen;
    res_t x;
    sb_q.push_back(r);
    kick(s, m, e);
    chk("busy_after_start", busy_m, 1);
    lat = 0; hold = 0; seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy_m && din_m == 5'd1) hold++;
      if (done_m) begin
        seen = 1'b1;
        break;
      end
    end
    x = sb_q.pop_front();
    if (!seen) begin
      timeout_fail("scan_done");
    end else begin
      chk("done_latency", 64'(lat), 64'(x.lat));
      chk("code_hold", 64'(hold), 64'(x.hold));
      chk("table_out", tbl_m, x.tbl);
      chk("mismatch_cnt", cnt_m, x.cnt);
      chk("any_miss", any_m, x.any);
      if (x.any) chk("first_miss_idx", first_m, x.first);
      chk("pass", pass_m, x.pass);
      chk("busy_at_done", busy_m, 0);
      @(negedge clk);
      chk("done_one_cycle", done_m, 0);
      chk("pass_held", pass_m, x.pass);
    end
  endtask

  initial begin
    bit ok;
    bit dseen;

    vecs[0] = '{1'b0, 0, 32'h96696996, '{32'h96696996, 6'd0,  1'b0, 5'd0,  1'b1, 64,  2}};
    vecs[1] = '{1'b0, 0, 32'h96696997, '{32'h96696996, 6'd1,  1'b1, 5'd0,  1'b0, 64,  2}};
    vecs[2] = '{1'b0, 1, 32'h00000000, '{32'hFFFFFFFF, 6'd32, 1'b1, 5'd0,  1'b0, 64,  2}};
    vecs[3] = '{1'b0, 0, 32'h96686D96, '{32'h96696996, 6'd2,  1'b1, 5'd10, 1'b0, 64,  2}};
    vecs[4] = '{1'b0, 3, 32'h00000000, '{32'h00000000, 6'd0,  1'b0, 5'd0,  1'b1, 64,  2}};
    vecs[5] = '{1'b1, 2, 32'h80000000, '{32'h80000000, 6'd0,  1'b0, 5'd0,  1'b1, 128, 4}};

    rst_n = 1'b0; start_r = 1'b0; abort_r = 1'b0; sel = 1'b0; mode_r = 0; exp_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  ifa.busy, 0);
    chk("rst_done",  ifa.done, 0);
    chk("rst_table", ifa.table_out, 0);
    chk("rst_cnt",   ifa.mismatch_cnt, 0);
    chk("rst_any",   ifa.any_miss, 0);
    chk("rst_first", ifa.first_miss_idx, 0);
    chk("rst_pass",  ifa.pass, 0);
    chk("rst_dutin", ifa.dut_in, 0);
    chk("rst_b_busy", ifb.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_scan(vecs[i].s, vecs[i].mode, vecs[i].exp, vecs[i].r);

    // start while busy is ignored, then abort mid-scan
    kick(1'b0, 0, 32'h96696996);
    wait_code(5, ok);
    if (!ok) timeout_fail("reach_code5");
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk("start_busy_ignored", busy_m, 1);
    chk("start_no_restart", 64'(din_m >= 5'd5), 1);
    wait_code(10, ok);
    if (!ok) timeout_fail("reach_code10");
    abort_r = 1'b1;
    @(posedge clk);
    #1 abort_r = 1'b0;
    chk("abort_busy", busy_m, 0);
    dseen = done_m;
    repeat (4) begin
      @(negedge clk);
      dseen = dseen | done_m;
    end
    chk("abort_no_done", dseen, 0);
    chk("abort_table_hi", tbl_m[31:10], 0);
    chk("abort_table_lo", tbl_m[9:0], 10'h196);
    chk("abort_cnt", cnt_m, 0);
    chk("abort_pass", pass_m, 0);
    run_scan(vecs[0].s, vecs[0].mode, vecs[0].exp, vecs[0].r);

    // asynchronous reset mid-scan
    kick(1'b0, 0, 32'h96696997);
    wait_code(20, ok);
    if (!ok) timeout_fail("reach_code20");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  busy_m, 0);
    chk("mid_rst_table", tbl_m, 0);
    chk("mid_rst_cnt",   cnt_m, 0);
    chk("mid_rst_any",   any_m, 0);
    chk("mid_rst_dutin", din_m, 0);
    chk("mid_rst_done",  done_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy_m, 0);
    chk("post_rst_dutin", din_m, 0);
    run_scan(vecs[0].s, vecs[0].mode, vecs[0].exp, vecs[0].r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
